// File: rtl/ram_dist_pkg.sv
// Shared types and elaboration helpers for the distributed single-port RAM
// with a hardware clear sweep.
package ram_dist_pkg;

  // Clear-sweep controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    FINISH = 2'd2
  } clr_state_t;

  // Address width needed to index 'depth' words (ceil(log2(depth))).
  function automatic int addr_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) begin
      w++;
    end
    return w;
  endfunction

  // True when n is a non-zero power of two.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/ram_dist_clr_ctrl.sv
// Clear-sweep sequencer: walks a pointer across every word exactly once,
// flags BUSY while it owns the write port and pulses DONE when finished.
module ram_dist_clr_ctrl
  import ram_dist_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  clr_state_t    state_reg, state_next;
  logic [AW-1:0] ptr_reg, ptr_next;
  logic          busy_reg, done_reg;

  // State, pointer and the registered BUSY/DONE flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      busy_reg  <= (state_next == SWEEP);
      done_reg  <= (state_next == FINISH);
    end
  end

  // Next-state logic; the sweep stops on the terminal compare, never wraps.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (clr) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        // CLR is deliberately ignored here so a sweep can never restart.
        if (ptr_reg == PTR_LAST) begin
          state_next = FINISH;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      FINISH: begin
        if (clr) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign ptr  = ptr_reg;

endmodule

// File: rtl/ram_dist_sp_clr.sv
// Distributed single-port RAM with selectable read latency, selectable
// active clock edge and a hardware sweep that fills every word with
// CLEAR_VAL. Memory contents are never touched by reset.
module ram_dist_sp_clr
  import ram_dist_pkg::*;
#(
  parameter int                         WIDTH      = 8,
  parameter int                         DEPTH      = 128,
  parameter logic [DEPTH*WIDTH-1:0]     INIT       = '0,
  parameter logic [WIDTH-1:0]           CLEAR_VAL  = '0,
  parameter bit                         OUT_REG    = 1'b0,
  parameter bit                         CLK_INVERT = 1'b1,
  localparam int                        AW         = addr_width(DEPTH)
) (
  input  logic             WCLK,
  input  logic             RST_N,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] D,
  input  logic             WE,
  input  logic             CLR,
  output logic [WIDTH-1:0] O,
  output logic             BUSY,
  output logic             DONE
);

  // Reject non-power-of-two depths at elaboration.
  if (!is_pow2(DEPTH)) begin : g_depth_check
    $fatal(1, "ram_dist_sp_clr: DEPTH must be a power of 2");
  end

  // All sequential logic runs on this internal clock, so one edge choice
  // covers the array, the output register and the sweep controller.
  logic clk_act;
  if (CLK_INVERT) begin : g_clk_fall
    assign clk_act = ~WCLK;
  end else begin : g_clk_rise
    assign clk_act = WCLK;
  end

  logic          sweep_busy;
  logic [AW-1:0] sweep_ptr;

  ram_dist_clr_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ctrl (
    .clk   (clk_act),
    .rst_n (RST_N),
    .clr   (CLR),
    .busy  (sweep_busy),
    .done  (DONE),
    .ptr   (sweep_ptr)
  );

  assign BUSY = sweep_busy;

  // Word n sits at bits [n*WIDTH +: WIDTH], matching the INIT layout; the
  // declaration value is the configuration-time content.
  logic [DEPTH-1:0][WIDTH-1:0] mem = INIT;

  // Write mux: the sweep owns the port while busy and user writes are lost.
  always_ff @(posedge clk_act) begin
    if (sweep_busy) begin
      mem[sweep_ptr] <= CLEAR_VAL;
    end else if (WE) begin
      mem[A] <= D;
    end
  end

  if (OUT_REG) begin : g_read_reg
    logic [WIDTH-1:0] o_reg;
    // Read-first output register: a same-edge write returns the old word.
    always_ff @(posedge clk_act or negedge RST_N) begin
      if (!RST_N) begin
        o_reg <= '0;
      end else begin
        o_reg <= mem[A];
      end
    end
    assign O = o_reg;
  end else begin : g_read_async
    assign O = mem[A];
  end

endmodule

// File: doc/ram_dist_sp_clr.md
RAM_DIST_SP_CLR -- requirements
Module: ram_dist_sp_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 128, word count, power of 2, 16..4096.
REQ-003 SHALL have parameter INIT, default all-zero, DEPTH*WIDTH-bit initial contents; word n at bits [n*WIDTH +: WIDTH].
REQ-004 SHALL have parameter CLEAR_VAL, default 0, WIDTH-bit value written by the clear sweep.
REQ-005 SHALL have parameter OUT_REG, default 0: 0 = asynchronous read, 1 = registered read.
REQ-006 SHALL have parameter CLK_INVERT, default 1: 1 = falling-edge active, 0 = rising-edge active.
REQ-007 SHALL have port WCLK, input, 1, the single clock; all sequential logic uses the active edge set by CLK_INVERT.
REQ-008 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port A, input, AW = log2(DEPTH), read/write address.
REQ-010 SHALL have port D, input, WIDTH, write data.
REQ-011 SHALL have port WE, input, 1, write enable.
REQ-012 SHALL have port CLR, input, 1, clear-sweep request, sampled on the active edge.
REQ-013 SHALL have port O, output, WIDTH, read data.
REQ-014 SHALL have port BUSY, output, 1, high while the sweep owns the write port.
REQ-015 SHALL have port DONE, output, 1, one-cycle pulse when the sweep completes.

Function
REQ-016 SHALL write D to mem[A] on the active edge when WE=1 and BUSY=0.
REQ-017 SHALL, with OUT_REG=0, drive O = mem[A] combinationally, new data visible right after the write edge.
REQ-018 SHALL, with OUT_REG=1, register O = mem[A] on each active edge, read-first: a same-edge write returns old data.
REQ-019 SHALL implement FSM states IDLE, SWEEP, FINISH.
REQ-020 SHALL go IDLE->SWEEP on an edge with CLR=1, loading pointer PTR=0.
REQ-021 SHALL, in SWEEP, write CLEAR_VAL to mem[PTR] each edge and increment PTR, going to FINISH on the edge that writes PTR=DEPTH-1 (DEPTH sweep writes total).
REQ-022 SHALL spend exactly one cycle in FINISH with DONE=1, then go to IDLE, or to SWEEP if CLR=1 on that edge.
REQ-023 SHALL register BUSY and drive it 1 exactly while the state is SWEEP.
REQ-024 SHALL ignore WE while BUSY=1; the rejected write is lost, no error flag.
REQ-025 SHALL ignore CLR during SWEEP; the sweep does not restart.
REQ-026 SHALL, when CLR=1 and WE=1 on the same IDLE or FINISH edge, perform the user write, after which the sweep overwrites it.
REQ-027 SHALL keep reads (REQ-017/018) functional during SWEEP.
REQ-028 SHALL never wrap PTR past DEPTH-1; termination is the terminal compare.

Reset
REQ-029 SHALL, on RST_N=0 and independent of WCLK, force state IDLE, PTR=0, BUSY=0, DONE=0, and the O register (OUT_REG=1) to 0.
REQ-030 SHALL leave memory contents untouched by reset; contents start from INIT at configuration only.
REQ-031 SHALL, on reset mid-sweep, keep already-cleared words at CLEAR_VAL and leave the rest unmodified.

Structure
REQ-032 SHALL place the state typedef (IDLE/SWEEP/FINISH), the AW derivation function and the DEPTH power-of-2 check in shared package ram_dist_pkg.
REQ-033 SHALL keep the FSM, PTR, BUSY and DONE in sub-module ram_dist_clr_ctrl, with the array, write mux and read path in the top.

Verification (WIDTH=8, DEPTH=128, CLEAR_VAL=0xFF unless stated)
REQ-034 SHALL cover: OUT_REG=0, write 0xA5@0x05 and 0x3C@0x7F -> O=0xA5 and 0x3C; unwritten 0x06 -> O=0x00.
REQ-035 SHALL cover: OUT_REG=1, mem[0x10]=0x11, write 0x22@0x10 -> O=0x11 after that edge, 0x22 after the next.
REQ-036 SHALL cover: fill mem[n]=n, pulse CLR -> BUSY high 128 cycles, one DONE pulse, all 128 reads =0xFF.
REQ-037 SHALL cover: WE=1, A=0x03, D=0x77 during BUSY -> ignored, mem[0x03]=0xFF after DONE; CLR mid-sweep -> no extra cycles.
REQ-038 SHALL cover: RST_N low after 40 sweep writes -> BUSY=DONE=0 at once; 0x00..0x27=0xFF, 0x28..0x7F keep fill values.
REQ-039 SHALL cover: CLK_INVERT=0 vs 1 -> the write lands only on the rising or the falling WCLK edge respectively.
